keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 12_000: clk cycles each column is driven, i.e. one dwell (1 ms at 12 MHz).
REQ-002 Parameter DEBOUNCE_SCANS, default 20: consecutive matching samples that confirm a press or a release.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on posedge clk; rst=0 resets.
REQ-005 rows  input  [4:7]  keypad row lines; active-high; asynchronous to clk.
REQ-006 cols  output  [0:3]  keypad column drive; one-hot, active-high; registered.
REQ-007 key_code  output  [3:0]  last confirmed key, encoded as col_index*4 + row_index (row_index = rows bit number minus 4).
REQ-008 key_coord  output  [0:7]  last confirmed key as {cols one-hot, rows one-hot}.
REQ-009 key_valid  output  1  one-cycle pulse per confirmed press.
REQ-010 key_pressed  output  1  level; high while a confirmed key is held.

Function
REQ-011 The block SHALL pass rows through a 2-flop synchronizer, reset to 0; all row decisions SHALL use the synchronized value.
REQ-012 A dwell counter SHALL count 0..SCAN_CYCLES-1 and then wrap; "dwell end" is the cycle the counter equals SCAN_CYCLES-1; width is clog2(SCAN_CYCLES).
REQ-013 The FSM SHALL have states SCAN, DEBOUNCE and HOLD; the dwell counter SHALL run continuously in all states.
REQ-014 In SCAN, at a dwell end with synced rows=0, col_index SHALL advance (3 wraps to 0) and cols SHALL show the new column from the next cycle.
REQ-015 In SCAN, at a dwell end with synced rows!=0, the block SHALL capture col_index and the lowest set row index (row 4 has highest priority), clear the debounce count and enter DEBOUNCE.
REQ-016 In DEBOUNCE and HOLD, cols SHALL stay frozen at the captured column.
REQ-017 In DEBOUNCE, at each dwell end:
- captured row bit 1: increment the count;
- captured row bit 0: return to SCAN and advance the column, with no outputs changed.
REQ-018 When the DEBOUNCE count reaches DEBOUNCE_SCANS, the block SHALL, in the next cycle:
- pulse key_valid for exactly one cycle;
- register key_code and key_coord;
- raise key_pressed;
- enter HOLD with the count cleared.
REQ-019 In HOLD, at each dwell end:
- captured row bit 0: increment the release count;
- captured row bit 1: clear the release count.
REQ-020 When the release count reaches DEBOUNCE_SCANS, the block SHALL drop key_pressed, return to SCAN and advance the column.
REQ-021 A held key SHALL produce exactly one key_valid (no auto-repeat); other keys SHALL be ignored while in DEBOUNCE or HOLD.
REQ-022 key_code and key_coord SHALL hold their values until the next confirmed press; release SHALL NOT clear them.
REQ-023 Latency: key_valid SHALL occur 1 cycle after the dwell end of the DEBOUNCE_SCANS-th confirming sample, that sample being counted after the detecting dwell end.

Reset
REQ-024 On rst=0 at posedge clk:
- state SCAN, col_index 0, cols[0]=1 and others 0;
- all counters and synchronizer flops cleared;
- key_code=0, key_coord=0, key_valid=0, key_pressed=0.
REQ-025 Reset SHALL override every state, including mid-DEBOUNCE and HOLD, and SHALL NOT emit key_valid.
REQ-026 Scanning SHALL resume from column 0 with a fresh dwell in the first cycle after rst returns to 1.

Verification
Common bench setup: SCAN_CYCLES=4, DEBOUNCE_SCANS=2. The keypad model sets rows[r]=1 iff cols[c]=1 and key (c,r) is pressed.
REQ-027 Reset: hold rst=0 for 3 cycles, then release -> cols=1000 and all outputs 0 during reset; afterwards cols steps 1000->0100->0010->0001->1000, changing every 4 cycles.
REQ-028 Press key (col2,row5) and hold -> cols freezes at 0010; exactly one key_valid pulse; key_code=4'd9; key_coord=8'b0010_0100; key_pressed=1.
REQ-029 Bounce: key (col1,row7) true for one dwell only -> no key_valid; key_pressed stays 0; cols advances to 0010.
REQ-030 Hold (col2,row5) for 100 dwells, then release -> one key_valid total; key_pressed falls after 2 low dwells; next column is 0001; key_code stays 9.
REQ-031 Press (col1,row4) and (col1,row6) together -> key_code=4'd4; key_coord=8'b0100_1000.
REQ-032 Assert rst=0 while in HOLD -> next cycle: all outputs 0, cols=1000, no key_valid pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column at a time, debounces a
// detected row, and reports each confirmed press once with its code.
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 12_000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:7] rows,
    output logic [0:3] cols,
    output logic [3:0] key_code,
    output logic [0:7] key_coord,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int DW_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DB_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [4:7]      rows_p0, rows_p1;
    logic [3:0]      row_vec;
    logic [DW_W-1:0] dwell_cnt;
    logic            dwell_end;
    logic [DB_W-1:0] deb_cnt, deb_n;
    logic [1:0]      col_idx, col_n, col_adv;
    logic [1:0]      cap_col, cap_col_n;
    logic [1:0]      cap_row, cap_row_n;
    logic [3:0]      code_n;
    logic [0:7]      coord_n;
    logic            valid_n;
    logic            pressed_n;

    // Lowest-numbered active row wins (row 4 has top priority).
    function automatic logic [1:0] low_row(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Column index to one-hot drive pattern (column 0 is the leftmost bit).
    function automatic logic [0:3] col_onehot(input logic [1:0] c);
        logic [0:3] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // {column one-hot, row one-hot} coordinate of a key.
    function automatic logic [0:7] coord_of(input logic [1:0] c, input logic [1:0] r);
        logic [0:7] v;
        v              = '0;
        v[{1'b0, c}]   = 1'b1;
        v[{1'b1, r}]   = 1'b1;
        return v;
    endfunction

    // --- stage p0/p1: two-flop synchronizer for the asynchronous row lines ---
    always_ff @(posedge clk) begin
        if (!rst) begin
            rows_p0 <= '0;
            rows_p1 <= '0;
        end else begin
            rows_p0 <= rows;
            rows_p1 <= rows_p0;
        end
    end

    // Row bit i of row_vec is synchronized row line 4+i.
    assign row_vec   = {rows_p1[7], rows_p1[6], rows_p1[5], rows_p1[4]};
    assign dwell_end = (dwell_cnt == DWELL_LAST);
    assign col_adv   = col_idx + 2'd1;

    // Free-running dwell counter; it keeps running in every FSM state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dwell_cnt <= '0;
        end else if (dwell_end) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Next-state and output decisions, evaluated only at dwell ends.
    always_comb begin
        state_n   = state;
        col_n     = col_idx;
        cap_col_n = cap_col;
        cap_row_n = cap_row;
        deb_n     = deb_cnt;
        code_n    = key_code;
        coord_n   = key_coord;
        valid_n   = 1'b0;
        pressed_n = key_pressed;
        case (state)
            SCAN: begin
                if (dwell_end) begin
                    if (row_vec != 4'd0) begin
                        cap_col_n = col_idx;
                        cap_row_n = low_row(row_vec);
                        deb_n     = '0;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_n = col_adv;
                    end
                end
            end
            DEBOUNCE: begin
                if (dwell_end) begin
                    if (row_vec[cap_row]) begin
                        if (deb_cnt == DB_LAST) begin
                            valid_n   = 1'b1;
                            code_n    = {cap_col, cap_row};
                            coord_n   = coord_of(cap_col, cap_row);
                            pressed_n = 1'b1;
                            deb_n     = '0;
                            state_n   = HOLD;
                        end else begin
                            deb_n = deb_cnt + 1'b1;
                        end
                    end else begin
                        col_n   = col_adv;
                        state_n = SCAN;
                    end
                end
            end
            HOLD: begin
                if (dwell_end) begin
                    if (!row_vec[cap_row]) begin
                        if (deb_cnt == DB_LAST) begin
                            pressed_n = 1'b0;
                            deb_n     = '0;
                            col_n     = col_adv;
                            state_n   = SCAN;
                        end else begin
                            deb_n = deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_n = '0;
                    end
                end
            end
            default: begin
                state_n = SCAN;
            end
        endcase
    end

    // State register plus all registered outputs and captured key.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            cols        <= col_onehot(2'd0);
            cap_col     <= 2'd0;
            cap_row     <= 2'd0;
            deb_cnt     <= '0;
            key_code    <= 4'd0;
            key_coord   <= '0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            state       <= state_n;
            col_idx     <= col_n;
            cols        <= col_onehot(col_n);
            cap_col     <= cap_col_n;
            cap_row     <= cap_row_n;
            deb_cnt     <= deb_n;
            key_code    <= code_n;
            key_coord   <= coord_n;
            key_valid   <= valid_n;
            key_pressed <= pressed_n;
        end
    end

endmodule
